// File: rtl/machine_driver_if.sv
// Signal bundle between the machine driver and its environment: the command
// handshake from the host, the control/data lines of the processing machine,
// and the result handshake back to the host.
interface machine_driver_if;
  // Command handshake (host -> driver)
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [1:0] cmd_on;

  // Machine control and data (driver <-> machine)
  logic [7:0] m_x;
  logic [1:0] m_on;
  logic       m_start;
  logic       m_active;
  logic [1:0] m_regime;
  logic [7:0] m_y;
  logic [2:0] m_s;
  logic       m_b;

  // Result handshake (driver -> host)
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_y;
  logic [2:0] res_s;
  logic       res_b;
  logic [1:0] res_regime;
  logic [1:0] res_err;
  logic [7:0] res_cycles;

  // Driver side
  modport master (
    input  cmd_valid, cmd_x, cmd_on,
    input  m_active, m_regime, m_y, m_s, m_b,
    input  res_ready,
    output cmd_ready,
    output m_x, m_on, m_start,
    output res_valid, res_y, res_s, res_b, res_regime, res_err, res_cycles
  );

  // Environment side (host plus machine)
  modport slave (
    output cmd_valid, cmd_x, cmd_on,
    output m_active, m_regime, m_y, m_s, m_b,
    output res_ready,
    input  cmd_ready,
    input  m_x, m_on, m_start,
    input  res_valid, res_y, res_s, res_b, res_regime, res_err, res_cycles
  );
endinterface

// File: rtl/machine_driver.sv
// Host-side initiator for the processing machine. Accepts one command, drives
// the machine operands and a single start pulse, follows the machine's active
// flag through acknowledge and completion, and presents the captured outputs
// (or an error code) as one result on a valid/ready handshake.
module machine_driver #(
  parameter int ACK_WAIT = 8,   // 1..255 cycles waiting for acknowledge
  parameter int TIMEOUT  = 64   // 1..255 active cycles before giving up
) (
  input logic             clk,
  input logic             rst,
  machine_driver_if.master bus
);

  localparam logic [7:0] ACK_LIM = 8'(ACK_WAIT);
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_NOACK = 2'b01;
  localparam logic [1:0] ERR_TOUT  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT_ACK,
    WAIT_DONE,
    RESULT
  } state_t;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;          // ack-wait / timeout counter
  logic [7:0] cyc_q, cyc_d;          // active cycles seen in WAIT_DONE
  logic [7:0] m_x_q, m_x_d;
  logic [1:0] m_on_q, m_on_d;
  logic [7:0] res_y_q, res_y_d;
  logic [2:0] res_s_q, res_s_d;
  logic       res_b_q, res_b_d;
  logic [1:0] res_regime_q, res_regime_d;
  logic [1:0] res_err_q, res_err_d;
  logic [7:0] res_cycles_q, res_cycles_d;

  logic [7:0] cnt_inc;
  logic [7:0] cyc_inc;

  assign cnt_inc = sat_inc8(cnt_q);
  assign cyc_inc = sat_inc8(cyc_q);

  // Handshake and strobe outputs are pure decodes of the registered state, so
  // they fall with the state on an asynchronous reset.
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.m_start    = (state_q == START);
  assign bus.res_valid  = (state_q == RESULT);

  assign bus.m_x        = m_x_q;
  assign bus.m_on       = m_on_q;
  assign bus.res_y      = res_y_q;
  assign bus.res_s      = res_s_q;
  assign bus.res_b      = res_b_q;
  assign bus.res_regime = res_regime_q;
  assign bus.res_err    = res_err_q;
  assign bus.res_cycles = res_cycles_q;

  // State, counters, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      cyc_q        <= 8'd0;
      m_x_q        <= 8'd0;
      m_on_q       <= 2'd0;
      res_y_q      <= 8'd0;
      res_s_q      <= 3'd0;
      res_b_q      <= 1'b0;
      res_regime_q <= 2'd0;
      res_err_q    <= ERR_OK;
      res_cycles_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      m_x_q        <= m_x_d;
      m_on_q       <= m_on_d;
      res_y_q      <= res_y_d;
      res_s_q      <= res_s_d;
      res_b_q      <= res_b_d;
      res_regime_q <= res_regime_d;
      res_err_q    <= res_err_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  // Next-state and register update logic; everything holds unless a state
  // explicitly changes it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    m_x_d        = m_x_q;
    m_on_d       = m_on_q;
    res_y_d      = res_y_q;
    res_s_d      = res_s_q;
    res_b_d      = res_b_q;
    res_regime_d = res_regime_q;
    res_err_d    = res_err_q;
    res_cycles_d = res_cycles_q;

    case (state_q)
      IDLE: begin
        // cmd_ready is high throughout IDLE, so valid alone completes the
        // handshake.
        if (bus.cmd_valid) begin
          m_x_d   = bus.cmd_x;
          m_on_d  = bus.cmd_on;
          state_d = SETUP;
        end
      end

      SETUP: begin
        // Give the machine one full cycle of stable operands before start.
        state_d = START;
      end

      START: begin
        cnt_d   = 8'd0;
        cyc_d   = 8'd0;
        state_d = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (bus.m_active) begin
          // An active flag already high here is taken as the acknowledge.
          cnt_d   = 8'd0;
          cyc_d   = 8'd0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == ACK_LIM) begin
            res_err_d    = ERR_NOACK;
            res_y_d      = 8'd0;
            res_s_d      = 3'd0;
            res_b_d      = 1'b0;
            res_regime_d = 2'd0;
            res_cycles_d = 8'd0;
            state_d      = RESULT;
          end
        end
      end

      WAIT_DONE: begin
        if (bus.m_active) begin
          cnt_d = cnt_inc;
          cyc_d = cyc_inc;
          if (cnt_inc == TO_LIM) begin
            // Give up but still report what the machine shows right now.
            res_err_d    = ERR_TOUT;
            res_y_d      = bus.m_y;
            res_s_d      = bus.m_s;
            res_b_d      = bus.m_b;
            res_regime_d = bus.m_regime;
            res_cycles_d = cyc_inc;
            state_d      = RESULT;
          end
        end else begin
          // Machine outputs are valid in the same cycle active drops.
          res_err_d    = ERR_OK;
          res_y_d      = bus.m_y;
          res_s_d      = bus.m_s;
          res_b_d      = bus.m_b;
          res_regime_d = bus.m_regime;
          res_cycles_d = cyc_q;
          state_d      = RESULT;
        end
      end

      RESULT: begin
        // Result registers keep their values after the handshake.
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_machine_driver.sv
// Directed bench for machine_driver: reset values, a normal run, missing
// acknowledge, timeout, result backpressure and an asynchronous reset in the
// middle of a run.
module tb_machine_driver;

  logic clk;
  logic rst;

  machine_driver_if bus ();

  machine_driver #(
    .ACK_WAIT (8),
    .TIMEOUT  (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Start-pulse monitor: total pulses and back-to-back occurrences.
  int   start_cnt  = 0;
  int   dbl_start  = 0;
  logic start_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.m_start && start_prev) dbl_start <= dbl_start + 1;
    if (bus.m_start) start_cnt <= start_cnt + 1;
    start_prev <= bus.m_start;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command while the driver is idle; it is taken at the next edge.
  task automatic accept(input logic [7:0] x, input logic [1:0] on);
    bus.cmd_valid = 1'b1;
    bus.cmd_x     = x;
    bus.cmd_on    = on;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Called 1 ns after the accept edge. The machine raises active after the
  // start pulse (acknowledged at accept+3), keeps it high for nhigh samples in
  // WAIT_DONE, then drops it together with its final outputs.
  // Returned latency is the number of edges from accept to res_valid.
  task automatic run_ack(input string tag, input int nhigh, input logic [7:0] y,
                         input logic [2:0] s, input logic b, input logic [1:0] rg,
                         output int lat);
    int k;
    k   = 0;
    lat = -1;
    chk({tag, "_setup_nostart"}, 32'(bus.m_start), 0);
    tick(); k++;
    chk({tag, "_start_pulse"}, 32'(bus.m_start), 1);
    tick(); k++;
    chk({tag, "_start_drop"}, 32'(bus.m_start), 0);
    bus.m_active = 1'b1;
    bus.m_y      = ~y;
    bus.m_s      = ~s;
    bus.m_b      = ~b;
    bus.m_regime = ~rg;
    for (int i = 0; i <= nhigh; i++) begin
      tick(); k++;
    end
    chk({tag, "_busy_novalid"}, 32'(bus.res_valid), 0);
    bus.m_active = 1'b0;
    bus.m_y      = y;
    bus.m_s      = s;
    bus.m_b      = b;
    bus.m_regime = rg;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      tick(); k++;
      if (bus.res_valid) lat = k;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int lat;
    int k;
    int seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_x     = 8'd0;
    bus.cmd_on    = 2'd0;
    bus.m_active  = 1'b0;
    bus.m_regime  = 2'd0;
    bus.m_y       = 8'd0;
    bus.m_s       = 3'd0;
    bus.m_b       = 1'b0;
    bus.res_ready = 1'b0;
    rst           = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_m_start", 32'(bus.m_start), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_m_x", 32'(bus.m_x), 0);
    chk("rst_m_on", 32'(bus.m_on), 0);
    chk("rst_res_err", 32'(bus.res_err), 0);
    chk("rst_res_cycles", 32'(bus.res_cycles), 0);
    rst = 1'b0;
    tick();

    // Normal run: 4 active samples in WAIT_DONE -> res_cycles 4, latency 8
    s0 = start_cnt;
    accept(8'hA5, 2'b10);
    chk("norm_m_x", 32'(bus.m_x), 32'hA5);
    chk("norm_m_on", 32'(bus.m_on), 2);
    chk("norm_cmd_ready_busy", 32'(bus.cmd_ready), 0);
    run_ack("norm", 4, 8'h3C, 3'd6, 1'b1, 2'b01, lat);
    chk("norm_latency", 32'(lat), 8);
    chk("norm_res_y", 32'(bus.res_y), 32'h3C);
    chk("norm_res_s", 32'(bus.res_s), 6);
    chk("norm_res_b", 32'(bus.res_b), 1);
    chk("norm_res_regime", 32'(bus.res_regime), 1);
    chk("norm_res_err", 32'(bus.res_err), 0);
    chk("norm_res_cycles", 32'(bus.res_cycles), 4);
    chk("norm_one_start", 32'(start_cnt - s0), 1);
    tick();
    chk("norm_hold_valid", 32'(bus.res_valid), 1);
    chk("norm_hold_y", 32'(bus.res_y), 32'h3C);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("norm_valid_drop", 32'(bus.res_valid), 0);
    chk("norm_cmd_ready_back", 32'(bus.cmd_ready), 1);
    chk("norm_res_y_kept", 32'(bus.res_y), 32'h3C);

    // No acknowledge: 8 low samples from accept+3 -> RESULT at accept+10
    s0  = start_cnt;
    accept(8'hC3, 2'b01);
    k   = 0;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      tick(); k++;
      if (bus.res_valid) lat = k;
    end
    chk("noack_latency", 32'(lat), 10);
    chk("noack_res_err", 32'(bus.res_err), 1);
    chk("noack_res_y", 32'(bus.res_y), 0);
    chk("noack_res_s", 32'(bus.res_s), 0);
    chk("noack_res_b", 32'(bus.res_b), 0);
    chk("noack_res_cycles", 32'(bus.res_cycles), 0);
    chk("noack_one_start", 32'(start_cnt - s0), 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Timeout: active already high on entry; m_y follows the cycle index so
    // the captured value pins down the capture cycle (edge 67 sees 66).
    bus.m_active = 1'b1;
    bus.m_s      = 3'd3;
    bus.m_b      = 1'b0;
    bus.m_regime = 2'b10;
    accept(8'h0F, 2'b11);
    bus.m_y = 8'd0;
    k   = 0;
    lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      tick(); k++;
      if (bus.res_valid) lat = k;
      else bus.m_y = 8'(k);
    end
    chk("tout_latency", 32'(lat), 67);
    chk("tout_res_err", 32'(bus.res_err), 2);
    chk("tout_res_cycles", 32'(bus.res_cycles), 64);
    chk("tout_res_y", 32'(bus.res_y), 32'h42);
    chk("tout_res_s", 32'(bus.res_s), 3);
    chk("tout_res_regime", 32'(bus.res_regime), 2);

    // Backpressure: result held 10 cycles while a new command waits
    bus.m_active  = 1'b0;
    s0            = start_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_x     = 8'h5A;
    bus.cmd_on    = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_res_valid", 32'(bus.res_valid), 1);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("bp_res_y", 32'(bus.res_y), 32'h42);
      chk("bp_res_cycles", 32'(bus.res_cycles), 64);
    end
    chk("bp_no_start", 32'(start_cnt - s0), 0);
    chk("bp_m_x_kept", 32'(bus.m_x), 32'h0F);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("bp_valid_drop", 32'(bus.res_valid), 0);
    chk("bp_cmd_ready_back", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp2_m_x", 32'(bus.m_x), 32'h5A);
    chk("bp2_m_on", 32'(bus.m_on), 1);
    run_ack("bp2", 2, 8'h99, 3'd1, 1'b1, 2'b11, lat);
    chk("bp2_latency", 32'(lat), 6);
    chk("bp2_res_y", 32'(bus.res_y), 32'h99);
    chk("bp2_res_s", 32'(bus.res_s), 1);
    chk("bp2_res_regime", 32'(bus.res_regime), 3);
    chk("bp2_res_err", 32'(bus.res_err), 0);
    chk("bp2_res_cycles", 32'(bus.res_cycles), 2);
    chk("bp2_one_start", 32'(start_cnt - s0), 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Asynchronous reset in the middle of WAIT_DONE
    accept(8'h77, 2'b10);
    tick();
    tick();
    bus.m_active = 1'b1;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_m_x", 32'(bus.m_x), 0);
    chk("arst_m_start", 32'(bus.m_start), 0);
    chk("arst_res_valid", 32'(bus.res_valid), 0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("arst_res_y", 32'(bus.res_y), 0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.m_active = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.res_valid) seen++;
    end
    chk("arst_no_result", 32'(seen), 0);
    chk("arst_idle", 32'(bus.cmd_ready), 1);
    chk("start_never_double", 32'(dbl_start), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
